// File: rtl/decoder_rr_arbiter.sv
// rtl/decoder_rr_arbiter.sv - round-robin arbiter for a shared 3-to-8 decode resource with hold limit
module decoder_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] req_i,
    output logic [7:0] gnt_o,
    output logic [2:0] gnt_idx_o,
    output logic       gnt_valid_o,
    output logic       preempt_o
);

    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
    localparam bit               LIM_EN   = (MAX_HOLD != 0);

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    state_e           state_q;
    logic [2:0]       ptr_q;
    logic [CNT_W-1:0] hold_cnt_q;
    logic [CNT_W-1:0] hold_cnt_d;
    logic [7:0]       gnt_q;
    logic [2:0]       gnt_idx_q;
    logic             gnt_valid_q;
    logic             preempt_q;

    logic [2:0]       win_idx;
    logic             win_found;

    // Scan downward so the candidate closest to ptr_q is the last one written.
    always_comb begin
        win_idx   = ptr_q;
        win_found = 1'b0;
        for (int k = 7; k >= 0; k--) begin
            if (req_i[ptr_q + 3'(k)]) begin
                win_idx   = ptr_q + 3'(k);
                win_found = 1'b1;
            end
        end
    end

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (hold_cnt_q != {CNT_W{1'b1}}) begin
            hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            ptr_q       <= 3'd0;
            hold_cnt_q  <= '0;
            gnt_q       <= 8'h00;
            gnt_idx_q   <= 3'd0;
            gnt_valid_q <= 1'b0;
            preempt_q   <= 1'b0;
        end else begin
            preempt_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (win_found) begin
                        state_q     <= BUSY;
                        gnt_idx_q   <= win_idx;
                        gnt_q       <= 8'd1 << win_idx;
                        gnt_valid_q <= 1'b1;
                        hold_cnt_q  <= CNT_W'(1);
                        ptr_q       <= win_idx + 3'd1;
                    end
                end
                BUSY: begin
                    // Release outranks the hold limit, so a tie never pulses preempt.
                    if (!req_i[gnt_idx_q]) begin
                        state_q     <= IDLE;
                        gnt_q       <= 8'h00;
                        gnt_valid_q <= 1'b0;
                        hold_cnt_q  <= '0;
                    end else if (LIM_EN && (hold_cnt_q == HOLD_LIM)) begin
                        state_q     <= IDLE;
                        gnt_q       <= 8'h00;
                        gnt_valid_q <= 1'b0;
                        hold_cnt_q  <= '0;
                        preempt_q   <= 1'b1;
                    end else begin
                        hold_cnt_q  <= hold_cnt_d;
                    end
                end
            endcase
        end
    end

    assign gnt_o       = gnt_q;
    assign gnt_idx_o   = gnt_idx_q;
    assign gnt_valid_o = gnt_valid_q;
    assign preempt_o   = preempt_q;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// tb/tb_decoder_rr_arbiter.sv - scoreboard bench for decoder_rr_arbiter
module tb_decoder_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] req2;
    logic [7:0] gnt, gnt2;
    logic [2:0] gnt_idx, gnt_idx2;
    logic       gnt_valid, gnt_valid2;
    logic       preempt, preempt2;

    always #5 clk = ~clk;

    decoder_rr_arbiter #(.MAX_HOLD(4), .CNT_W(8)) u_dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .req_i      (req),
        .gnt_o      (gnt),
        .gnt_idx_o  (gnt_idx),
        .gnt_valid_o(gnt_valid),
        .preempt_o  (preempt)
    );

    decoder_rr_arbiter #(.MAX_HOLD(0), .CNT_W(8)) u_dut0 (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .req_i      (req2),
        .gnt_o      (gnt2),
        .gnt_idx_o  (gnt_idx2),
        .gnt_valid_o(gnt_valid2),
        .preempt_o  (preempt2)
    );

    typedef struct {
        int kind;   // 0 = grant start, 1 = grant end
        int idx;
        int len;
        bit pre;
    } ev_t;

    ev_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void exp_grant(int idx);
        ev_t e;
        e.kind = 0; e.idx = idx; e.len = 0; e.pre = 1'b0;
        exp_q.push_back(e);
    endfunction

    function automatic void exp_end(int idx, int len, bit pre);
        ev_t e;
        e.kind = 1; e.idx = idx; e.len = len; e.pre = pre;
        exp_q.push_back(e);
    endfunction

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 8'h00;
        step(2);
        rst_n = 1'b1;
    endtask

    // Monitor: turns grant start/end into events and pops the scoreboard
    bit  prev_valid = 1'b0;
    int  cur_idx    = 0;
    int  cur_len    = 0;
    ev_t me;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            check("valid_vs_or_gnt", 32'(gnt_valid), 32'(|gnt));
            if (gnt_valid && !prev_valid) begin
                cur_idx = int'(gnt_idx);
                cur_len = 1;
                if (exp_q.size() == 0) begin
                    check("unexpected_grant", 32'(gnt_idx), 32'hFFFF_FFFF);
                end else begin
                    me = exp_q.pop_front();
                    check("grant_event_kind", 32'd0, 32'(me.kind));
                    check("grant_idx", 32'(gnt_idx), 32'(me.idx));
                    check("grant_vec", 32'(gnt), 32'(1) << me.idx);
                end
            end else if (gnt_valid) begin
                cur_len++;
                check("idx_stable", 32'(gnt_idx), 32'(cur_idx));
                check("gnt_onehot", 32'(gnt), 32'(1) << cur_idx);
            end else if (prev_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_end", 32'(cur_idx), 32'hFFFF_FFFF);
                end else begin
                    me = exp_q.pop_front();
                    check("end_event_kind", 32'd1, 32'(me.kind));
                    check("end_idx", 32'(cur_idx), 32'(me.idx));
                    check("grant_len", 32'(cur_len), 32'(me.len));
                    check("end_preempt", 32'(preempt), 32'(me.pre));
                    check("end_gnt_zero", 32'(gnt), 32'd0);
                end
            end else begin
                check("idle_no_preempt", 32'(preempt), 32'd0);
            end
            prev_valid = gnt_valid;
        end
    end

    initial begin
        rst_n = 1'b0;
        req   = 8'h00;
        req2  = 8'h00;
        step(2);
        check("rst_gnt", 32'(gnt), 32'h00);
        check("rst_idx", 32'(gnt_idx), 32'd0);
        check("rst_valid", 32'(gnt_valid), 32'd0);
        check("rst_preempt", 32'(preempt), 32'd0);
        check("rst_gnt_nolim", 32'(gnt2), 32'h00);
        rst_n = 1'b1;

        // Reset in the middle of a grant
        req = 8'h20;
        exp_grant(5);
        step(1);
        check("pre_reset_gnt", 32'(gnt), 32'h20);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_gnt", 32'(gnt), 32'h00);
        check("async_rst_idx", 32'(gnt_idx), 32'd0);
        check("async_rst_valid", 32'(gnt_valid), 32'd0);
        check("async_rst_preempt", 32'(preempt), 32'd0);
        check("async_rst_ptr", 32'(u_dut.ptr_q), 32'd0);
        step(2);
        rst_n = 1'b1;
        exp_grant(5);
        step(1);
        check("post_reset_gnt", 32'(gnt), 32'h20);
        req = 8'h00;
        exp_end(5, 1, 1'b0);
        step(2);

        // Rotation 0..7,0 with each winner dropping one cycle after grant
        do_reset();
        req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            exp_grant(i % 8);
            exp_end(i % 8, 1, 1'b0);
            step(1);
            if (i == 7) check("ptr_wrap", 32'(u_dut.ptr_q), 32'd0);
            req[i % 8] = 1'b0;
            step(1);
            req[i % 8] = 1'b1;
        end
        req = 8'h00;
        step(2);

        // Fairness: wrap from ptr 3 to requester 0, then skip to 2
        do_reset();
        req = 8'h04;
        exp_grant(2);
        step(1);
        req = 8'h00;
        exp_end(2, 1, 1'b0);
        step(1);
        check("ptr_after_2", 32'(u_dut.ptr_q), 32'd3);
        req = 8'h05;
        exp_grant(0);
        step(1);
        req = 8'h00;
        exp_end(0, 1, 1'b0);
        step(1);
        req = 8'h05;
        exp_grant(2);
        step(1);
        req = 8'h00;
        exp_end(2, 1, 1'b0);
        step(2);

        // Hold limit with a single requester
        do_reset();
        req = 8'h01;
        exp_grant(0);
        exp_end(0, 4, 1'b1);
        exp_grant(0);
        step(5);
        check("preempt_pulse", 32'(preempt), 32'd1);
        step(1);
        req = 8'h00;
        exp_end(0, 1, 1'b0);
        step(2);

        // Hold limit with a competitor: regrant goes to 1
        do_reset();
        req = 8'h03;
        exp_grant(0);
        exp_end(0, 4, 1'b1);
        exp_grant(1);
        step(6);
        req = 8'h00;
        exp_end(1, 1, 1'b0);
        step(2);

        // Release and limit on the same edge
        do_reset();
        req = 8'h01;
        exp_grant(0);
        step(4);
        req = 8'h00;
        exp_end(0, 4, 1'b0);
        step(1);
        check("tie_no_preempt", 32'(preempt), 32'd0);
        step(2);

        // Limit disabled: grant never drops, counter saturates
        req2 = 8'h80;
        step(1);
        for (int c = 0; c < 300; c++) begin
            check("nolimit_hold", {22'd0, preempt2, gnt_valid2, gnt2}, {22'd0, 1'b0, 1'b1, 8'h80});
            step(1);
        end
        check("nolimit_cnt_sat", 32'(u_dut0.hold_cnt_q), 32'd255);
        check("nolimit_idx", 32'(gnt_idx2), 32'd7);
        req2 = 8'h00;
        step(2);
        check("nolimit_release", 32'(gnt_valid2), 32'd0);

        step(3);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/decoder_rr_arbiter.md
# decoder_rr_arbiter

Round-robin arbiter that shares one 3-bit-select/8-line-output decode resource among eight requesters. It grants one requester at a time, holds the grant while that requester keeps its request asserted, and drives both the 3-bit index (to the decoder select input) and a registered one-hot grant vector. A hold-time limit stops any single requester from monopolising the resource.

## Interface
- MAX_HOLD, 16: maximum grant duration in cycles; 0 disables the limit.
- CNT_W, 8: hold-counter width; MAX_HOLD must be < 2^CNT_W.
- CLK  input  1  rising-edge clock.
- RST_N  input  1  asynchronous, active-low reset; single clock domain.
- REQ  input  8  request vector, bit i = requester i; level-held while the resource is wanted.
- GNT  output  8  registered one-hot grant; all-zero when nothing is granted.
- GNT_IDX  output  3  index of the granted requester, valid when GNT_VALID=1.
- GNT_VALID  output  1  a grant is active.
- PREEMPT  output  1  one-cycle pulse: the current grant was revoked by the hold limit.

## Operation
- States: IDLE (no grant) and BUSY (grant held). Internal: PTR[2:0] (search start), HOLD_CNT[CNT_W-1:0].
- IDLE: at an edge with REQ≠0, select the first set bit of REQ scanning PTR, PTR+1, …, 7, 0, … (mod 8).
  - Load GNT_IDX=winner, GNT=1<<winner, GNT_VALID=1, HOLD_CNT=1.
  - Set PTR=winner+1 mod 8 (7 wraps to 0); go to BUSY.
  - With REQ=0, stay in IDLE; outputs and PTR are unchanged.
- BUSY, evaluated in this priority order at each edge:
  - Release: REQ[GNT_IDX]=0 → IDLE; GNT=0, GNT_VALID=0, HOLD_CNT=0.
  - Preempt: MAX_HOLD≠0 and HOLD_CNT=MAX_HOLD → IDLE; GNT=0, GNT_VALID=0, PREEMPT=1 for exactly one cycle.
  - Otherwise: stay in BUSY; HOLD_CNT increments, saturating at 2^CNT_W−1 when MAX_HOLD=0.
- Other REQ bits changing while BUSY do not affect the grant.
- Invariants:
  - GNT is either zero or exactly one-hot, and equals 1<<GNT_IDX whenever GNT_VALID=1.
  - GNT_VALID = |GNT.
- GNT_IDX holds its last value while GNT_VALID=0. Consumers must qualify it with GNT_VALID.
- A preempted requester that keeps REQ high competes again at the next arbitration. It has lowest priority because PTR has moved past it.
- Reset (RST_N low, at any time including mid-grant) forces, asynchronously:
  - state=IDLE, GNT=8'h00, GNT_IDX=3'd0, GNT_VALID=0, PREEMPT=0, PTR=3'd0, HOLD_CNT=0.
- After RST_N deasserts, the first arbitration occurs on the first rising edge.

## Timing
- Grant latency: REQ is sampled at edge n; GNT, GNT_IDX and GNT_VALID become valid after edge n (1 cycle from a request set before edge n).
- Release latency: REQ[GNT_IDX] is sampled low at edge n; GNT drops after edge n.
- Re-arbitration needs one more edge, so there is always ≥1 cycle with GNT=0 between consecutive grants.
- Grant duration with a steady request: exactly MAX_HOLD cycles of GNT_VALID=1, then PREEMPT is high for the one cycle in which GNT_VALID=0.
- All outputs are registered; there is no combinational path from REQ to any output.
- Simultaneous release and limit on the same edge: release wins, and PREEMPT stays 0.

## Test plan
- Reset mid-grant: grant requester 5, pull RST_N low between edges → GNT=00, GNT_IDX=0, GNT_VALID=0, PREEMPT=0 immediately; after release, REQ=8'h20 → GNT=8'h20 one edge later.
- Rotation: after reset hold REQ=8'hFF and drop each winner's request one cycle after it is granted → grant order 0,1,2,…,7,0 with one idle cycle between grants; PTR wraps 7→0.
- Fairness/skip: PTR=3, REQ=8'h05 → grant 0 (wrap, skipping 3..7); next PTR=1, REQ=8'h05 → grant 2.
- Hold limit: MAX_HOLD=4, REQ=8'h01 held → GNT_VALID high for exactly 4 cycles, PREEMPT pulse of 1 cycle, regrant to 0 one cycle later; with REQ=8'h03 → the regrant goes to 1.
- Release/limit tie: MAX_HOLD=4, drop REQ[idx] so it is sampled low at the 4th grant edge → GNT=0, PREEMPT stays 0.
- Limit disabled: MAX_HOLD=0, REQ=8'h80 held for 300 cycles → grant never drops, HOLD_CNT saturates at 255, PREEMPT never asserts.
